pipe_mux_n: RTL and testbench
=============================

// Module: pipe_mux_n
// PURPOSE
//  Parametrised N-way datapath selector with a registered, flow-controlled output.
//  - Generalises the fixed 3:1 combinational operand mux to NUM_IN inputs of DATA_WIDTH.
//  - Adds a valid/ready handshake through a 2-entry skid buffer, so stalls in the
//    multicycle datapath back-pressure cleanly.
//  - Defines out-of-range selects: zero data plus an error flag. No latched hold value.
// PARAMETERS
//  DATA_WIDTH  32                 width of each input and of out_data
//  NUM_IN      4                  number of inputs, 2..16
//  SEL_WIDTH   $clog2(NUM_IN)     select width; must be >= 1
//  CNT_WIDTH   16                 width of the saturating select-error counter
// PORTS
//  clk            in   1                    rising-edge clock
//  reset          in   1                    synchronous, active-high reset
//  in_data        in   NUM_IN*DATA_WIDTH    packed inputs; input k = [k*DATA_WIDTH +: DATA_WIDTH]
//  in_sel         in   SEL_WIDTH            input index, sampled with in_data
//  in_valid       in   1                    upstream word valid
//  in_ready       out  1                    block can accept a word this cycle
//  out_data       out  DATA_WIDTH           selected word
//  out_sel_err    out  1                    word was produced from an out-of-range select
//  out_valid      out  1                    out_data/out_sel_err valid
//  out_ready      in   1                    downstream accepts a word
//  sel_err_count  out  CNT_WIDTH            saturating count of accepted bad selects
// BEHAVIOUR
//  - Single clock domain. reset is synchronous and active-high and wins over all other events.
//  - Reset values:
//    - out_valid = 0, out_data = 0, out_sel_err = 0.
//    - sel_err_count = 0, in_ready = 1.
//    - Both buffer entries are invalid.
//  - Select decode (combinational, ahead of the buffer):
//    - in_sel < NUM_IN: word = input[in_sel], err = 0.
//    - in_sel >= NUM_IN: word = 0, err = 1.
//  - Transfers:
//    - Input transfer: in_valid && in_ready on a clock edge.
//    - Output transfer: out_valid && out_ready on a clock edge.
//  - Latency and throughput:
//    - Latency is 1 cycle: an accepted word appears on out_* the next cycle.
//    - Sustained throughput is 1 word/cycle while out_ready = 1.
//  - Buffer entries:
//    - Main entry drives out_*.
//    - Skid entry catches the word accepted in the cycle out_ready drops.
//  - in_ready is a flop equal to !skid_valid. There is no combinational path from out_ready.
//  - Occupancy FSM:
//    - EMPTY:
//      - input transfer -> ONE; the word loads main.
//    - ONE:
//      - input and output transfers together -> ONE; main reloads.
//      - output transfer only -> EMPTY.
//      - input transfer only -> TWO; the word loads skid.
//      - neither -> ONE.
//    - TWO (in_ready = 0):
//      - output transfer -> ONE; skid moves to main and skid is cleared.
//      - otherwise -> TWO.
//  - While out_valid = 1 and out_ready = 0, out_data and out_sel_err are held stable.
//  - out_data is a don't-care while out_valid = 0. The RTL drives the last value and does
//    not clear it.
//  - sel_err_count:
//    - Increments by 1 on each input transfer with err = 1.
//    - Saturates at 2^CNT_WIDTH-1, with no wrap-around.
//    - Counts at acceptance, not at delivery.
//  - in_valid = 1 with in_ready = 0: no state change; upstream must hold its word.
//  - Reset mid-operation: buffered words are discarded and not delivered. The counter clears.
// STRUCTURE
//  - Package mux_pkg holds:
//    - typedef occ_t {EMPTY=2'd0, ONE=2'd1, TWO=2'd2}.
//    - Function sel_in_range(sel, n).
//    - Constant ERR_CNT_MAX.
//  - Sub-module skid_buf #(WIDTH=DATA_WIDTH+1):
//    - Generic 2-entry valid/ready skid buffer carrying {err, word}.
//    - Reusable at other stall points.
//  - Top level contains the decode, the skid_buf instance and the error counter.
// TESTING
//  1. Reset and idle: assert reset 2 cycles with in_valid = 1
//     -> out_valid = 0, in_ready = 1 during reset, sel_err_count = 0.
//  2. Streaming: NUM_IN = 4, inputs 0x11/0x22/0x33/0x44, sel 0..3 back-to-back, out_ready = 1
//     -> out_data 0x11, 0x22, 0x33, 0x44 on consecutive cycles, each 1 cycle after acceptance.
//  3. Bad select: NUM_IN = 3, in_sel = 3
//     -> out_data = 0, out_sel_err = 1, sel_err_count = 1; a following sel = 2 gives input 2 with err = 0.
//  4. Back-pressure: drop out_ready while streaming A, B, C
//     -> in_ready = 0 after B enters skid; output holds A stable.
//     -> On release, A, B, C are delivered in order with no loss or duplication.
//  5. Saturation: CNT_WIDTH = 2, 5 accepted bad selects -> sel_err_count = 3 with no wrap.
//  6. Reset mid-operation: reset while in state TWO
//     -> next cycle out_valid = 0 and in_ready = 1; old words never appear.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the flow-controlled N-way operand selector.
package mux_pkg;

   // Occupancy of the 2-entry skid buffer.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   // All-ones ceiling; truncated to the counter width by the user.
   localparam logic [31:0] ERR_CNT_MAX = 32'hFFFF_FFFF;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
      return sel < n;
   endfunction

endpackage

// File: rtl/pipe_mux_n_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; main entry drives the output,
// skid entry absorbs the word accepted in the cycle downstream stalls.
module skid_buf
   import mux_pkg::*;
#(
   parameter int unsigned WIDTH = 33
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   occ_t             occ;
   logic [WIDTH-1:0] skid_q;
   logic             in_xfer;
   logic             out_xfer;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   // in_ready is registered as !skid_valid, so out_ready never reaches it combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         occ       <= EMPTY;
         out_data  <= '0;
         skid_q    <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (occ)
            EMPTY: begin
               if (in_xfer) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  occ       <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  out_data <= in_data;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  occ       <= EMPTY;
               end else if (in_xfer) begin
                  skid_q   <= in_data;
                  in_ready <= 1'b0;
                  occ      <= TWO;
               end
            end
            TWO: begin
               if (out_xfer) begin
                  out_data <= skid_q;
                  skid_q   <= '0;
                  in_ready <= 1'b1;
                  occ      <= ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               occ       <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_mux_n.sv
// Parametrised N-way selector feeding a skid buffer; out-of-range selects
// yield zero data with an error flag and bump a saturating counter.
module pipe_mux_n
   import mux_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_IN     = 4,
   parameter int unsigned SEL_WIDTH  = $clog2(NUM_IN),
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
   input  logic [SEL_WIDTH-1:0]         in_sel,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_sel_err,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CNT_WIDTH-1:0]         sel_err_count
);

   localparam int unsigned BUF_WIDTH = DATA_WIDTH + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(ERR_CNT_MAX);

   logic [DATA_WIDTH-1:0] sel_word;
   logic                  sel_err;
   logic [BUF_WIDTH-1:0]  buf_out;

   // Select decode; a bad select never indexes past the packed input bus.
   always_comb begin
      sel_word = '0;
      sel_err  = !sel_in_range(32'(in_sel), NUM_IN);
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_WIDTH'(k)) begin
            sel_word = in_data[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   skid_buf #(
      .WIDTH (BUF_WIDTH)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({sel_err, sel_word}),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_sel_err = buf_out[DATA_WIDTH];
   assign out_data    = buf_out[DATA_WIDTH-1:0];

   // Errors are counted when the word is accepted, not when it is delivered.
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_err_count <= '0;
      end else if (in_valid && in_ready && sel_err && (sel_err_count != CNT_MAX)) begin
         sel_err_count <= sel_err_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: a 4-input and a 3-input/2-bit-counter instance share
// one stimulus stream and are checked every cycle against a queue model.
module tb_pipe_mux_n;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        in_valid;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_err;
   logic [7:0]  a_out_data;
   logic [15:0] a_cnt;
   logic        b_in_ready, b_out_valid, b_out_err;
   logic [7:0]  b_out_data;
   logic [1:0]  b_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_mux_n #(.DATA_WIDTH(8), .NUM_IN(4), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_sel_err(a_out_err), .out_valid(a_out_valid), .out_ready(out_ready),
      .sel_err_count(a_cnt));

   pipe_mux_n #(.DATA_WIDTH(8), .NUM_IN(3), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset), .in_data(in_data[23:0]), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_sel_err(b_out_err), .out_valid(b_out_valid), .out_ready(out_ready),
      .sel_err_count(b_cnt));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the block behaves as a 2-deep FIFO of {err, word}.
   logic [8:0] qa[$];
   logic [8:0] qb[$];
   int         ca, cb;
   bit         armed = 1'b0;

   function automatic logic [8:0] decode(input int n, input logic [1:0] s, input logic [31:0] d);
      if (int'(s) < n) return {1'b0, d[int'(s)*8 +: 8]};
      return {1'b1, 8'h00};
   endfunction

   always @(posedge clk) begin
      bit acc_in, acc_out;
      logic [8:0] wa, wb;
      if (reset) begin
         qa.delete(); qb.delete(); ca = 0; cb = 0; armed = 1'b1;
      end else if (armed) begin
         acc_in  = in_valid && (qa.size() < 2);
         acc_out = out_ready && (qa.size() > 0);
         if (acc_out) begin
            void'(qa.pop_front()); void'(qb.pop_front());
         end
         if (acc_in) begin
            wa = decode(4, in_sel, in_data);
            wb = decode(3, in_sel, in_data);
            qa.push_back(wa); qb.push_back(wb);
            if (wa[8] && ca < 65535) ca++;
            if (wb[8] && cb < 3) cb++;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("a_in_ready", 32'(a_in_ready), 32'(qa.size() < 2));
         chk("a_out_valid", 32'(a_out_valid), 32'(qa.size() > 0));
         chk("a_cnt", 32'(a_cnt), 32'(ca));
         if (qa.size() > 0) chk("a_out", {23'd0, a_out_err, a_out_data}, 32'(qa[0]));
         chk("b_in_ready", 32'(b_in_ready), 32'(qb.size() < 2));
         chk("b_out_valid", 32'(b_out_valid), 32'(qb.size() > 0));
         chk("b_cnt", 32'(b_cnt), 32'(cb));
         if (qb.size() > 0) chk("b_out", {23'd0, b_out_err, b_out_data}, 32'(qb[0]));
      end
   end

   // Apply inputs at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic drive(input logic r, input logic v, input logic [1:0] s, input logic ordy);
      reset = r; in_valid = v; in_sel = s; out_ready = ordy;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b1; in_sel = 2'd0; out_ready = 1'b0;
      in_data = 32'h4433_2211;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      chk("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_out_data", 32'(a_out_data), 32'd0);
      chk("rst_b_cnt", 32'(b_cnt), 32'd0);

      // Streaming, one word per cycle.
      drive(0, 1, 2'd0, 1); chk("str0", 32'(a_out_data), 32'h11);
      drive(0, 1, 2'd1, 1); chk("str1", 32'(a_out_data), 32'h22);
      drive(0, 1, 2'd2, 1); chk("str2", 32'(a_out_data), 32'h33);
      drive(0, 1, 2'd3, 1); chk("str3", 32'(a_out_data), 32'h44);
      chk("bad_b_data", 32'(b_out_data), 32'h0);
      chk("bad_b_err", 32'(b_out_err), 32'd1);
      chk("bad_b_cnt", 32'(b_cnt), 32'd1);
      chk("good_a_err", 32'(a_out_err), 32'd0);
      drive(0, 1, 2'd2, 1);
      chk("after_bad_data", 32'(b_out_data), 32'h33);
      chk("after_bad_err", 32'(b_out_err), 32'd0);
      drive(0, 0, 2'd0, 1); chk("drained", 32'(a_out_valid), 32'd0);

      // Back-pressure with A, B, C.
      drive(0, 1, 2'd0, 0); chk("bp_a", 32'(a_out_data), 32'h11);
      drive(0, 1, 2'd1, 0);
      chk("bp_full", 32'(a_in_ready), 32'd0);
      chk("bp_hold1", 32'(a_out_data), 32'h11);
      drive(0, 1, 2'd2, 0); chk("bp_hold2", 32'(a_out_data), 32'h11);
      drive(0, 1, 2'd2, 1); chk("bp_b", 32'(a_out_data), 32'h22);
      chk("bp_ready", 32'(a_in_ready), 32'd1);
      drive(0, 1, 2'd2, 1); chk("bp_c", 32'(a_out_data), 32'h33);
      drive(0, 0, 2'd0, 1); chk("bp_empty", 32'(a_out_valid), 32'd0);

      // Reset while full.
      drive(0, 1, 2'd3, 0);
      drive(0, 1, 2'd1, 0); chk("two_state", 32'(a_in_ready), 32'd0);
      drive(1, 1, 2'd0, 0);
      chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
      chk("mid_rst_ready", 32'(a_in_ready), 32'd1);
      chk("mid_rst_cnt", 32'(b_cnt), 32'd0);
      drive(0, 0, 2'd0, 1); chk("no_stale", 32'(a_out_valid), 32'd0);
      drive(0, 0, 2'd0, 1);

      // Saturation of the 2-bit counter.
      drive(0, 1, 2'd3, 1); chk("sat1", 32'(b_cnt), 32'd1);
      drive(0, 1, 2'd3, 1); chk("sat2", 32'(b_cnt), 32'd2);
      drive(0, 1, 2'd3, 1); chk("sat3", 32'(b_cnt), 32'd3);
      drive(0, 1, 2'd3, 1); chk("sat4", 32'(b_cnt), 32'd3);
      drive(0, 1, 2'd3, 1); chk("sat5", 32'(b_cnt), 32'd3);
      chk("sat_a_cnt", 32'(a_cnt), 32'd0);
      drive(0, 0, 2'd0, 1);
      drive(0, 0, 2'd0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
